// File: rtl/cla8_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract that drives one external 8-bit CLA slice, LSB byte first.
// Optional zero-result flag output: define CLA_SEQ_ZERO_FLAG_EN.
module cla8_seq_adder #(
    parameter  int WIDTH  = 32,
    localparam int NSLICE = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic [7:0]       slice_a,
    output logic [7:0]       slice_b,
    output logic             slice_cin,
    input  logic [7:0]       slice_s,
    input  logic             slice_cout
`ifdef CLA_SEQ_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [NSLICE-1:0][7:0] a_reg, b_reg, res_reg;
    logic [IDXW-1:0]        idx;
    logic                   carry;
    logic                   accept;
    logic                   last;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == RUN) && (idx == LAST);
    assign result = res_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        slice_a   = 8'h00;
        slice_b   = 8'h00;
        slice_cin = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                slice_a   = a_reg[idx];
                slice_b   = b_reg[idx];
                slice_cin = carry;
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: invert B on accept and seed the carry with sub.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
        end else if (state == RUN) begin
            res_reg[idx] <= slice_s;
            carry        <= slice_cout;
            idx          <= idx + 1'b1;
            if (last) begin
                cout <= slice_cout;
                ovf  <= (a_reg[NSLICE-1][7] == b_reg[NSLICE-1][7]) &&
                        (slice_s[7] != a_reg[NSLICE-1][7]);
            end
        end
    end

`ifdef CLA_SEQ_ZERO_FLAG_EN
    logic zero_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_acc <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            zero_acc <= 1'b1;
        end else if (state == RUN) begin
            zero_acc <= zero_acc && (slice_s == 8'h00);
            if (last) zero <= zero_acc && (slice_s == 8'h00);
        end
    end
`endif

endmodule

// File: tb/tb_cla8_seq_adder.sv
// Bench for cla8_seq_adder (WIDTH=32) with a behavioural 8-bit CLA on the slice ports.
// Define CLA_SEQ_ZERO_FLAG_EN for both files to also check the zero flag.
module tb_cla8_seq_adder;

    localparam int W = 32;
    localparam int NS = W / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0, b = '0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          cout, ovf;
    logic [7:0]    slice_a, slice_b, slice_s;
    logic          slice_cin, slice_cout;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    logic          zero;
`endif

    cla8_seq_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_s(slice_s), .slice_cout(slice_cout)
`ifdef CLA_SEQ_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    // External 8-bit adder slice.
    assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {8'h00, slice_cin};

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         sub;
        logic [W-1:0] res;
        logic         cout, ovf;
    } vec_t;

    vec_t tbl[10];
    vec_t pending;
    vec_t sb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, acc_cyc = 0;
    logic ov_q = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm, input int n);
        checks++;
        errors++;
        $display("FAIL timeout %s: waited %0d cycles", nm, n);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, pop and compare on result handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sb.push_back(pending);
                acc_cyc = cyc + 1;
            end
            if (out_valid && !ov_q) chk("latency", 64'(cyc - acc_cyc), 64'(NS));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(result), 64'hDEAD);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    chk("result", 64'(result), 64'(e.res));
                    chk("cout", 64'(cout), 64'(e.cout));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
`ifdef CLA_SEQ_ZERO_FLAG_EN
                    chk("zero", 64'(zero), 64'(e.res == '0));
`endif
                end
            end
        end
        ov_q = out_valid;
    end

    task automatic present(input vec_t v);
        @(posedge clk); #1;
        pending  = v;
        a        = v.a;
        b        = v.b;
        sub      = v.sub;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(output int n);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) tmo("accept", n);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) tmo("out_valid", n);
    endtask

    task automatic run_op(input vec_t v);
        int n;
        present(v);
        wait_accept(n);
        wait_valid();
        @(posedge clk); #1;
    endtask

    function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        vec_t         v;
        logic [W-1:0] yy;
        logic [W:0]   t;
        yy    = s ? ~y : y;
        t     = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
        v.a   = x;  v.b = y;  v.sub = s;
        v.res = t[W-1:0];
        v.cout = t[W];
        v.ovf = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return v;
    endfunction

    initial begin
        int   n;
        vec_t v;
        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[2] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
        tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[7] = '{32'h00000100, 32'h00000100, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[8] = '{32'h00000100, 32'h000000FF, 1'b1, 32'h00000001, 1'b1, 1'b0};
        tbl[9] = '{32'h0000FF00, 32'h00000100, 1'b0, 32'h00010000, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_slice", 64'({slice_a, slice_b, slice_cin}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(tbl[i]);

        for (int i = 0; i < 6; i++) run_op(model($urandom, $urandom, 1'($urandom_range(0, 1))));

        // Backpressure: result held, new operands wait until DONE is released.
        out_ready = 1'b0;
        present(tbl[2]);
        wait_accept(n);
        wait_valid();
        @(posedge clk); #1;
        present(model(32'h0000FFFF, 32'h00000001, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_result", 64'(result), 64'h2);
            chk("bp_slice_a", 64'(slice_a), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept(n);
        chk("bp_accept_delay", 64'(n), 64'd1);
        wait_valid();
        @(posedge clk); #1;

        // Reset while idx==2 abandons the operation.
        v = model(32'h44332211, 32'h01010101, 1'b0);
        present(v);
        wait_accept(n);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_slice_a", 64'(slice_a), 64'h33);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_result", 64'(result), 64'd0);
        run_op('{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0});

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
